vga_scan_timer: RTL and testbench
=================================

# vga_scan_timer

Free-running scan-timing generator for the baby VGA peripheral. It feeds the peripheral's framebuffer read port and pixel output stage with a 32×16 cell position, sync pulses, blanking, a 3-bit read phase, and a once-per-frame interrupt. It runs a 1024×768@60 raster directly from the 64 MHz TinyQV clock, one clock per native pixel. Each cell is 32 clocks wide and 48 lines tall.

## Interface
Parameters:
- H_ACTIVE, 1024, active clocks per line
- H_FRONT, 24, horizontal front porch clocks
- H_SYNC, 136, hsync width in clocks
- H_BACK, 160, horizontal back porch clocks; line total is 1344
- V_ACTIVE, 768, active lines
- V_FRONT, 3, vertical front porch lines
- V_SYNC, 6, vsync width in lines
- V_BACK, 29, vertical back porch lines; frame total is 806
- ROW_LINES, 48, lines per cell row

Ports:
- clk  in  1  system clock, 64 MHz
- rst_n  in  1  asynchronous, active-low reset
- cli  in  1  interrupt clear pulse, sampled on the clk edge
- x_pos  out  5  cell column, h_count[9:5] when h_count < 1024, otherwise 0
- y_pos  out  4  cell row
- hsync  out  1  horizontal sync, active low
- vsync  out  1  vertical sync, active low
- blank  out  1  high outside the 1024×768 active area
- counter  out  3  h_count[2:0], the framebuffer read phase
- interrupt  out  1  frame interrupt, sticky until cleared

## Operation
State registers: h_count (11b, 0..1343), v_count (10b, 0..805), line_in_row (6b, 0..47), row (4b), irq (1b).
- All outputs decode combinationally from these registers only. There is no input-to-output combinational path.
- h_count increments every clock. At 1343 it wraps to 0, and v_count advances (805 wraps to 0).
- At the h_count==1343 edge with v_count < 768:
  - line_in_row increments.
  - At 47 it wraps to 0 and row increments, 4-bit wrap.
  - After line 767, line_in_row and row are both 0 (16 rows wrap naturally).
  - They hold during vertical blanking, so y_pos = 0 through blanking and the framebuffer pre-addresses row 0.
- y_pos = row.
- hsync = 0 iff 1048 ≤ h_count < 1184.
- vsync = 0 iff 771 ≤ v_count < 777.
- blank = (h_count ≥ 1024) | (v_count ≥ 768).
- irq set condition: h_count==0 && v_count==768, i.e. the first cycle of the vertical front porch.
- irq clear: cli==1 clears irq on the next edge.
- Simultaneous set and cli: set wins, and irq stays 1.
- interrupt = irq.

## Timing
- Reset, asynchronous, takes effect immediately: all counters 0, irq 0.
  - Outputs during reset: x_pos 0, y_pos 0, hsync 1, vsync 1, blank 0, counter 0, interrupt 0.
- Cycle k after reset release: h_count = k mod 1344.
- Frame length is 1,083,264 clocks, about 59.08 Hz. Line rate is about 47.62 kHz.
- x_pos changes every 32 clocks. counter cycles 0..7 continuously. Line length is a multiple of 8, so counter is 0 at every line start.
- Interrupt:
  - interrupt rises at cycle 1,032,192 (768×1344) of each frame.
  - interrupt falls on the edge after a cli pulse.
  - cli while irq=0 has no effect.
- Reset asserted mid-frame: all state returns to reset values asynchronously. After release, the raster restarts from h=0, v=0 with no partial-frame artefacts.

## Test plan
- Reset, then release:
  - All outputs equal the reset values at cycle 0.
  - At cycle 1023: blank=0, x_pos=31.
  - At cycle 1024: blank=1, x_pos=0.
- Horizontal sync: hsync falls at cycle 1048, rises at 1184, and the pattern repeats at 1344+1048. counter is 0 at cycles 0, 8, and 1344.
- Row stepping: y_pos goes 0→1 at cycle 48×1344 = 64,512, reaches 15 at 720×1344, and returns to 0 at 768×1344 with blank=1.
- Vertical sync and interrupt:
  - vsync is low from cycle 771×1344 through 777×1344−1.
  - interrupt rises at 1,032,192.
  - v_count wraps at 1,083,264 with blank=0 and y_pos=0.
- cli handling:
  - A cli pulse at cycle 1,040,000 drops interrupt the next cycle.
  - cli held high across cycle 1,032,192 of the next frame still leaves interrupt=1 after that edge.
- Mid-frame reset: assert rst_n=0 at cycle 500,000 for 3 clocks. Outputs go to reset values immediately, and after release hsync first falls 1048 cycles later.

Source files
------------

// File: rtl/vga_scan_timer.sv
// vga_scan_timer
//   Free-running raster timing generator for the baby VGA peripheral. It runs
//   1024x768@60 at one clock per pixel from the 64 MHz system clock. The
//   framebuffer is 32x16 cells, and each cell is 32 clocks wide and ROW_LINES
//   lines tall.
//
// Ports
//   clk        system clock (one pixel per clock)
//   rst_n      asynchronous active-low reset
//   cli        interrupt clear pulse, sampled on the clk edge
//   x_pos[4:0] cell column (h_count[9:5] inside the active line, else 0)
//   y_pos[3:0] cell row (held at 0 through vertical blanking)
//   hsync      horizontal sync, active low
//   vsync      vertical sync, active low
//   blank      high outside the active area
//   counter    framebuffer read phase, h_count[2:0]
//   interrupt  once-per-frame interrupt, sticky until cleared by cli
module vga_scan_timer #(
  parameter int H_ACTIVE  = 1024,
  parameter int H_FRONT   = 24,
  parameter int H_SYNC    = 136,
  parameter int H_BACK    = 160,
  parameter int V_ACTIVE  = 768,
  parameter int V_FRONT   = 3,
  parameter int V_SYNC    = 6,
  parameter int V_BACK    = 29,
  parameter int ROW_LINES = 48
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cli,
  output logic [4:0] x_pos,
  output logic [3:0] y_pos,
  output logic       hsync,
  output logic       vsync,
  output logic       blank,
  output logic [2:0] counter,
  output logic       interrupt
);

  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [10:0] H_ACT_END  = 11'(H_ACTIVE);
  localparam logic [10:0] H_SYNC_BEG = 11'(H_ACTIVE + H_FRONT);
  localparam logic [10:0] H_SYNC_END = 11'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [10:0] H_LAST     = 11'(H_TOTAL - 1);

  localparam logic [9:0]  V_ACT_END  = 10'(V_ACTIVE);
  localparam logic [9:0]  V_ACT_LAST = 10'(V_ACTIVE - 1);
  localparam logic [9:0]  V_SYNC_BEG = 10'(V_ACTIVE + V_FRONT);
  localparam logic [9:0]  V_SYNC_END = 10'(V_ACTIVE + V_FRONT + V_SYNC);
  localparam logic [9:0]  V_LAST     = 10'(V_TOTAL - 1);

  localparam logic [5:0]  ROW_LAST   = 6'(ROW_LINES - 1);

  logic [10:0] h_count;
  logic [9:0]  v_count;
  logic [5:0]  line_in_row;
  logic [3:0]  row;
  logic        irq;

  logic line_end;
  logic irq_set;

  assign line_end = (h_count == H_LAST);

  // The set is decoded one clock early (last clock of the last active line)
  // so that irq is already high in the cycle where h_count==0 and
  // v_count==V_ACTIVE, the first cycle of the vertical front porch.
  assign irq_set = line_end && (v_count == V_ACT_LAST);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_count     <= '0;
      v_count     <= '0;
      line_in_row <= '0;
      row         <= '0;
      irq         <= 1'b0;
    end else begin
      h_count <= line_end ? '0 : h_count + 11'd1;

      if (line_end) begin
        v_count <= (v_count == V_LAST) ? '0 : v_count + 10'd1;

        // Cell row tracking only moves during active lines; it holds at 0
        // through vertical blanking so the framebuffer pre-addresses row 0.
        if (v_count == V_ACT_LAST) begin
          line_in_row <= '0;
          row         <= '0;
        end else if (v_count < V_ACT_END) begin
          if (line_in_row == ROW_LAST) begin
            line_in_row <= '0;
            row         <= row + 4'd1;
          end else begin
            line_in_row <= line_in_row + 6'd1;
          end
        end
      end

      // Set has priority over a simultaneous clear.
      if (irq_set) begin
        irq <= 1'b1;
      end else if (cli) begin
        irq <= 1'b0;
      end
    end
  end

  // Outputs decode from registered state only.
  assign x_pos     = (h_count < H_ACT_END) ? h_count[9:5] : 5'd0;
  assign y_pos     = row;
  assign hsync     = !((h_count >= H_SYNC_BEG) && (h_count < H_SYNC_END));
  assign vsync     = !((v_count >= V_SYNC_BEG) && (v_count < V_SYNC_END));
  assign blank     = (h_count >= H_ACT_END) || (v_count >= V_ACT_END);
  assign counter   = h_count[2:0];
  assign interrupt = irq;

endmodule

// File: tb/tb_vga_scan_timer.sv
// tb_vga_scan_timer
//   Directed bench for vga_scan_timer. The "big" instance uses the native
//   1024x768 timing for the horizontal, first row step and mid-frame reset
//   behaviour. The "small" instance uses a shrunk raster so that whole-frame
//   behaviour (row wrap, vsync, interrupt, cli) fits in a short run:
//     small: H 64/8/16/16 (total 104), V 32/3/6/5 (total 46), ROW_LINES 2,
//     frame = 4784 clocks, interrupt rises at 32*104 = 3328.
//   Cycle k means the interval after the k-th rising edge following the
//   reset release; outputs are sampled 1 time unit after that edge.
module tb_vga_scan_timer;

  logic clk;
  logic b_rst_n, s_rst_n;
  logic b_cli, s_cli;

  logic [4:0] b_x, s_x;
  logic [3:0] b_y, s_y;
  logic       b_hs, s_hs, b_vs, s_vs, b_blank, s_blank, b_int, s_int;
  logic [2:0] b_cnt, s_cnt;

  int cyc;
  int n_total;
  int n_pass;

  vga_scan_timer dut_big (
    .clk       (clk),
    .rst_n     (b_rst_n),
    .cli       (b_cli),
    .x_pos     (b_x),
    .y_pos     (b_y),
    .hsync     (b_hs),
    .vsync     (b_vs),
    .blank     (b_blank),
    .counter   (b_cnt),
    .interrupt (b_int)
  );

  vga_scan_timer #(
    .H_ACTIVE (64), .H_FRONT (8), .H_SYNC (16), .H_BACK (16),
    .V_ACTIVE (32), .V_FRONT (3), .V_SYNC (6),  .V_BACK (5),
    .ROW_LINES(2)
  ) dut_small (
    .clk       (clk),
    .rst_n     (s_rst_n),
    .cli       (s_cli),
    .x_pos     (s_x),
    .y_pos     (s_y),
    .hsync     (s_hs),
    .vsync     (s_vs),
    .blank     (s_blank),
    .counter   (s_cnt),
    .interrupt (s_int)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    n_total++;
    assert (observed === expected) n_pass++;
    else $error("FAIL %s at cycle %0d: observed %0d expected %0d",
                tag, cyc, observed, expected);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic wait_to(input int k);
    while (cyc < k) step();
  endtask

  // Full reset-value check of the big instance.
  task automatic check_big_reset(input string tag);
    check({tag, " x_pos"},     32'(b_x),     32'd0);
    check({tag, " y_pos"},     32'(b_y),     32'd0);
    check({tag, " hsync"},     32'(b_hs),    32'd1);
    check({tag, " vsync"},     32'(b_vs),    32'd1);
    check({tag, " blank"},     32'(b_blank), 32'd0);
    check({tag, " counter"},   32'(b_cnt),   32'd0);
    check({tag, " interrupt"}, 32'(b_int),   32'd0);
  endtask

  initial begin
    cyc     = 0;
    n_total = 0;
    n_pass  = 0;
    b_cli   = 1'b0;
    s_cli   = 1'b0;
    b_rst_n = 1'b0;
    s_rst_n = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check_big_reset("in_reset");
    check("in_reset small interrupt", 32'(s_int), 32'd0);

    @(negedge clk);
    b_rst_n = 1'b1;
    s_rst_n = 1'b1;
    cyc     = 0;

    check_big_reset("cycle0");
    check("cycle0 small blank", 32'(s_blank), 32'd0);

    wait_to(5);
    check("counter phase 5", 32'(b_cnt), 32'd5);
    wait_to(8);
    check("counter at 8", 32'(b_cnt), 32'd0);
    check("x_pos at 8", 32'(b_x), 32'd0);

    // Small raster: row steps every 2 lines (208 clocks).
    wait_to(207);
    check("small y before step", 32'(s_y), 32'd0);
    wait_to(208);
    check("small y after step", 32'(s_y), 32'd1);

    wait_to(1023);
    check("blank at 1023", 32'(b_blank), 32'd0);
    check("x_pos at 1023", 32'(b_x), 32'd31);
    wait_to(1024);
    check("blank at 1024", 32'(b_blank), 32'd1);
    check("x_pos at 1024", 32'(b_x), 32'd0);

    wait_to(1047);
    check("hsync at 1047", 32'(b_hs), 32'd1);
    wait_to(1048);
    check("hsync at 1048", 32'(b_hs), 32'd0);
    wait_to(1183);
    check("hsync at 1183", 32'(b_hs), 32'd0);
    wait_to(1184);
    check("hsync at 1184", 32'(b_hs), 32'd1);

    wait_to(1344);
    check("counter at line 1", 32'(b_cnt), 32'd0);
    check("blank at line 1", 32'(b_blank), 32'd0);
    check("y at line 1", 32'(b_y), 32'd0);
    wait_to(2391);
    check("hsync at 2391", 32'(b_hs), 32'd1);
    wait_to(2392);
    check("hsync at 2392", 32'(b_hs), 32'd0);

    // Small raster: last row, then wrap to 0 at the start of vblank.
    wait_to(3120);
    check("small y last row", 32'(s_y), 32'd15);
    wait_to(3327);
    check("small y before vblank", 32'(s_y), 32'd15);
    check("small int before vblank", 32'(s_int), 32'd0);
    wait_to(3328);
    check("small y in vblank", 32'(s_y), 32'd0);
    check("small blank in vblank", 32'(s_blank), 32'd1);
    check("small int rise", 32'(s_int), 32'd1);

    wait_to(3639);
    check("small vsync before", 32'(s_vs), 32'd1);
    wait_to(3640);
    check("small vsync start", 32'(s_vs), 32'd0);
    wait_to(4263);
    check("small vsync end", 32'(s_vs), 32'd0);
    wait_to(4264);
    check("small vsync after", 32'(s_vs), 32'd1);

    wait_to(4784);
    check("small wrap blank", 32'(s_blank), 32'd0);
    check("small wrap y", 32'(s_y), 32'd0);
    check("small int sticky", 32'(s_int), 32'd1);

    // cli pulse clears on the following edge.
    wait_to(4800);
    s_cli = 1'b1;
    check("small int before cli", 32'(s_int), 32'd1);
    step();
    s_cli = 1'b0;
    check("small int after cli", 32'(s_int), 32'd0);

    // cli held across the next set edge: set wins.
    wait_to(8110);
    s_cli = 1'b1;
    step();
    check("small int before set", 32'(s_int), 32'd0);
    step();
    s_cli = 1'b0;
    check("small set beats cli", 32'(s_int), 32'd1);
    step();
    check("small int held", 32'(s_int), 32'd1);

    // Native raster: first row step at 48 lines.
    wait_to(64511);
    check("y before row step", 32'(b_y), 32'd0);
    wait_to(64512);
    check("y after row step", 32'(b_y), 32'd1);

    // Mid-frame reset: h = 65000 - 64512 = 488, so x_pos = 15, y_pos = 1.
    wait_to(65000);
    check("x before reset", 32'(b_x), 32'd15);
    b_rst_n = 1'b0;
    #1;
    check_big_reset("async reset");
    repeat (3) @(posedge clk);
    @(negedge clk);
    b_rst_n = 1'b1;
    cyc     = 0;
    check("restart hsync c0", 32'(b_hs), 32'd1);
    check("restart y c0", 32'(b_y), 32'd0);
    wait_to(1047);
    check("restart hsync 1047", 32'(b_hs), 32'd1);
    wait_to(1048);
    check("restart hsync 1048", 32'(b_hs), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
